// File: rtl/seg_capture_decoder.sv
// seg_capture_decoder: observes a multiplexed, active-low seven-segment bus,
// waits for each digit pattern to settle, and decodes it back to a hex nibble
// stored per digit position.
// Optional build macro: SEG_BLANK_DETECT_EN -- when defined, the all-off
// pattern is a legal "blank" that clears the digit's valid bit without
// raising pattern_err.

// Per-digit storage slot: owns one nibble and its valid bit.
module seg_digit_slot (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr,
  input  logic       hit,
  input  logic [3:0] val,
  output logic [3:0] value,
  output logic       valid
);
  // Write on capture; a miss (bad or blank pattern) clears valid but keeps the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
      valid <= 1'b0;
    end else if (wr) begin
      valid <= hit;
      if (hit) value <= val;
    end
  end
endmodule

module seg_capture_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [6:0]                    seg_n,
  input  logic [NUM_DIGITS-1:0]         dig_en,
  output logic [4*NUM_DIGITS-1:0]       digit_value,
  output logic [NUM_DIGITS-1:0]         digit_valid,
  output logic                          capture_strb,
  output logic [$clog2(NUM_DIGITS)-1:0] capture_idx,
  output logic                          pattern_err
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} state_t;

  state_t                         state, state_d;
  logic [1:0]                     rst_ff;
  logic                           rst_s_n;
  logic [1:0][6:0]                seg_sy;
  logic [1:0][NUM_DIGITS-1:0]     dig_sy;
  logic [6:0]                     snap_seg, snap_seg_d;
  logic [NUM_DIGITS-1:0]          snap_dig, snap_dig_d;
  logic [CW-1:0]                  cnt, cnt_d;
  logic                           same, oh, cap_en, hit, blank_ok;
  logic [3:0]                     dval;
  logic [NUM_DIGITS-1:0]          wr_vec;
  logic [NUM_DIGITS-1:0][3:0]     val_arr;

  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    case (s)
      7'b1000000: seg_decode = {1'b1, 4'h0};
      7'b1111001: seg_decode = {1'b1, 4'h1};
      7'b0100100: seg_decode = {1'b1, 4'h2};
      7'b0110000: seg_decode = {1'b1, 4'h3};
      7'b0011001: seg_decode = {1'b1, 4'h4};
      7'b0010010: seg_decode = {1'b1, 4'h5};
      7'b0000010: seg_decode = {1'b1, 4'h6};
      7'b1111000: seg_decode = {1'b1, 4'h7};
      7'b0000000: seg_decode = {1'b1, 4'h8};
      7'b0011000: seg_decode = {1'b1, 4'h9};
      7'b0001000: seg_decode = {1'b1, 4'hA};
      7'b0000011: seg_decode = {1'b1, 4'hB};
      7'b0100111: seg_decode = {1'b1, 4'hC};
      7'b0100001: seg_decode = {1'b1, 4'hD};
      7'b0000110: seg_decode = {1'b1, 4'hE};
      7'b0001110: seg_decode = {1'b1, 4'hF};
      default:    seg_decode = 5'b0;
    endcase
  endfunction

  function automatic logic [IW-1:0] enc(input logic [NUM_DIGITS-1:0] d);
    enc = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (d[i]) enc = IW'(i);
  endfunction

  // Reset synchronizer: assert immediately, release on a clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_ff <= '0;
    else          rst_ff <= {rst_ff[0], 1'b1};
  end
  assign rst_s_n = rst_ff[1];

  // Two-flop synchronizers on the asynchronous display pins.
  always_ff @(posedge clk or negedge rst_s_n) begin
    if (!rst_s_n) begin
      seg_sy <= '1;
      dig_sy <= '0;
    end else begin
      seg_sy <= {seg_sy[0], seg_n};
      dig_sy <= {dig_sy[0], dig_en};
    end
  end

  assign same = (seg_sy[1] == snap_seg) && (dig_sy[1] == snap_dig);
  assign oh   = $onehot(dig_sy[1]);

  // State, snapshot and stability counter registers.
  always_ff @(posedge clk or negedge rst_s_n) begin
    if (!rst_s_n) begin
      state    <= IDLE;
      snap_seg <= '0;
      snap_dig <= '0;
      cnt      <= '0;
    end else begin
      state    <= state_d;
      snap_seg <= snap_seg_d;
      snap_dig <= snap_dig_d;
      cnt      <= cnt_d;
    end
  end

  // Next-state: settle on a one-hot snapshot, capture once, hold until the bus moves.
  always_comb begin
    state_d    = state;
    snap_seg_d = snap_seg;
    snap_dig_d = snap_dig;
    cnt_d      = cnt;
    case (state)
      IDLE: if (oh) begin
        snap_seg_d = seg_sy[1];
        snap_dig_d = dig_sy[1];
        cnt_d      = CW'(1);
        state_d    = SETTLE;
      end
      SETTLE: begin
        if (same) begin
          if (cnt == CMAX) state_d = CAPTURE;
          else             cnt_d   = cnt + 1'b1;
        end else if (oh) begin
          snap_seg_d = seg_sy[1];
          snap_dig_d = dig_sy[1];
          cnt_d      = CW'(1);
        end else begin
          state_d = IDLE;
        end
      end
      CAPTURE: state_d = HOLD;
      HOLD:    if (!same) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign {hit, dval} = seg_decode(snap_seg);
  assign cap_en      = (state == CAPTURE);
  assign wr_vec      = {NUM_DIGITS{cap_en}} & snap_dig;

`ifdef SEG_BLANK_DETECT_EN
  assign blank_ok = (snap_seg == 7'b111_1111);
`else
  assign blank_ok = 1'b0;
`endif

  // Capture strobes, registered so they leave the block glitch-free.
  always_ff @(posedge clk or negedge rst_s_n) begin
    if (!rst_s_n) begin
      capture_strb <= 1'b0;
      pattern_err  <= 1'b0;
      capture_idx  <= '0;
    end else begin
      capture_strb <= cap_en && hit;
      pattern_err  <= cap_en && !hit && !blank_ok;
      if (cap_en && hit) capture_idx <= enc(snap_dig);
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_slot
    seg_digit_slot u_slot (
      .clk   (clk),
      .rst_n (rst_s_n),
      .wr    (wr_vec[g]),
      .hit   (hit),
      .val   (dval),
      .value (val_arr[g]),
      .valid (digit_valid[g])
    );
  end

  assign digit_value = val_arr;
endmodule

// File: tb/tb_seg_capture_decoder.sv
// Directed bench for seg_capture_decoder (NUM_DIGITS=4, STABLE_CYCLES=4).
module tb_seg_capture_decoder;
  localparam int ND = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [6:0]    seg_n = 7'h7F;
  logic [ND-1:0] dig_en = '0;
  logic [4*ND-1:0] digit_value;
  logic [ND-1:0] digit_valid;
  logic          capture_strb;
  logic [1:0]    capture_idx;
  logic          pattern_err;

  int nvec = 0, nerr = 0, nstrb = 0, nperr = 0, nboth = 0;
  logic [7:0] idx_log = '0;
  logic [6:0] pat2 [4] = '{7'h79, 7'h08, 7'h27, 7'h0E};

  always #5 clk = ~clk;

  seg_capture_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .seg_n        (seg_n),
    .dig_en       (dig_en),
    .digit_value  (digit_value),
    .digit_valid  (digit_valid),
    .capture_strb (capture_strb),
    .capture_idx  (capture_idx),
    .pattern_err  (pattern_err)
  );

  // Tally pulses seen in the cycle that ends at this edge.
  always @(posedge clk) begin
    if (capture_strb === 1'b1) begin
      nstrb++;
      idx_log = {idx_log[5:0], capture_idx};
    end
    if (pattern_err === 1'b1) nperr++;
    if (capture_strb === 1'b1 && pattern_err === 1'b1) nboth++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr();
    nstrb = 0; nperr = 0; idx_log = '0;
  endtask

  initial begin
    #1 reset_n = 1'b0;
    step(3);
    chk("rst_value", digit_value, 0);
    chk("rst_valid", digit_valid, 0);
    chk("rst_strb",  capture_strb, 0);
    chk("rst_err",   pattern_err, 0);
    chk("rst_idx",   capture_idx, 0);
    reset_n = 1'b1;
    step(4);

    // 1: digit 0 shows "2"; strobe lands exactly 7 cycles after the first sampling edge
    clr(); dig_en = 4'b0001; seg_n = 7'h24;
    step(7);
    chk("t1_early_strb", capture_strb, 0);
    step(1);
    chk("t1_strb",  capture_strb, 1);
    chk("t1_idx",   capture_idx, 0);
    chk("t1_value", digit_value[3:0], 4'h2);
    chk("t1_valid", digit_valid, 4'b0001);
    step(20);
    chk("t1_no_recapture", nstrb, 1);

    // 2: scan 1,A,c,F across digits 0..3
    clr();
    for (int i = 0; i < 4; i++) begin
      dig_en = 4'b0001 << i;
      seg_n  = pat2[i];
      step(8);
    end
    step(2);
    chk("t2_value", digit_value, 16'hFCA1);
    chk("t2_valid", digit_valid, 4'hF);
    chk("t2_nstrb", nstrb, 4);
    chk("t2_idxseq", idx_log, 8'h1B);

    // 3: toggling 3/5 every 2 cycles never settles, then holding 5 captures
    clr(); dig_en = 4'b0100;
    for (int k = 0; k < 10; k++) begin
      seg_n = k[0] ? 7'h12 : 7'h30;
      step(2);
    end
    chk("t3_toggle_strb", nstrb, 0);
    chk("t3_toggle_err",  nperr, 0);
    step(10);
    chk("t3_nstrb", nstrb, 1);
    chk("t3_idx",   idx_log, 8'h02);
    chk("t3_value", digit_value, 16'hF5A1);

    // 4: unknown pattern on digit 1
    clr(); dig_en = 4'b0010; seg_n = 7'h55;
    step(10);
    chk("t4_nperr", nperr, 1);
    chk("t4_nstrb", nstrb, 0);
    chk("t4_valid", digit_valid, 4'b1101);
    chk("t4_value", digit_value, 16'hF5A1);

    // 5: multi-hot and zero-hot enables are ignored
    clr(); dig_en = 4'b0011; seg_n = 7'h24;
    step(10);
    chk("t5_multi_strb", nstrb, 0);
    chk("t5_multi_err",  nperr, 0);
    dig_en = 4'b0000;
    step(10);
    chk("t5_zero_strb", nstrb, 0);
    chk("t5_zero_err",  nperr, 0);
    chk("t5_valid",     digit_valid, 4'b1101);

    // blank pattern on digit 3
    clr(); dig_en = 4'b1000; seg_n = 7'h7F;
    step(10);
    chk("blank_valid", digit_valid, 4'b0101);
    chk("blank_strb",  nstrb, 0);
`ifdef SEG_BLANK_DETECT_EN
    chk("blank_err", nperr, 0);
`else
    chk("blank_err", nperr, 1);
`endif
    chk("blank_value", digit_value, 16'hF5A1);

    // 6: reset while settling with cnt=3
    clr(); dig_en = 4'b0001; seg_n = 7'h00;
    step(6);
    reset_n = 1'b0;
    #1;
    chk("t6_value", digit_value, 0);
    chk("t6_valid", digit_valid, 0);
    chk("t6_strb",  capture_strb, 0);
    chk("t6_err",   pattern_err, 0);
    chk("t6_idx",   capture_idx, 0);
    @(negedge clk);
    reset_n = 1'b1; dig_en = 4'b0000;
    step(10);
    chk("t6_post_strb",  nstrb, 0);
    chk("t6_post_valid", digit_valid, 0);

    // fresh capture after reset
    clr(); dig_en = 4'b0001; seg_n = 7'h00;
    step(8);
    chk("t7_strb",  capture_strb, 1);
    chk("t7_value", digit_value, 16'h0008);
    chk("t7_valid", digit_valid, 4'b0001);
    step(2);
    chk("never_both", nboth, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
